// File: rtl/vga_timing.sv
// vga_timing: free-running VGA timing generator (default 1024x768@60, 65 MHz pclk).
// Revision 1.0 - initial release.
`default_nettype none

module vga_timing #(
  parameter int H_ACTIVE     = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_WIDTH = 136,
  parameter int H_TOTAL      = 1344,
  parameter int V_ACTIVE     = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_WIDTH = 6,
  parameter int V_TOTAL      = 806
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_start_out,
  output logic [7:0]  frame_cnt_out
);

  localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_ACTIVE = 11'(V_ACTIVE);
  localparam logic [10:0] C_HS_BEG   = 11'(H_SYNC_START);
  localparam logic [10:0] C_HS_END   = 11'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [10:0] C_VS_BEG   = 11'(V_SYNC_START);
  localparam logic [10:0] C_VS_END   = 11'(V_SYNC_START + V_SYNC_WIDTH);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        fstart_q, fstart_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        w_h_wrap;
  logic        w_frame_wrap;

  // Flags are decoded from the next counts so every registered output
  // describes the same pixel in the same cycle.
  always_comb begin
    w_h_wrap     = (hcount_q == C_H_LAST);
    w_frame_wrap = w_h_wrap && (vcount_q == C_V_LAST);

    hcount_d = w_h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (w_h_wrap) begin
      vcount_d = (vcount_q == C_V_LAST) ? 11'd0 : vcount_q + 11'd1;
    end

    hsync_d  = (hcount_d >= C_HS_BEG) && (hcount_d < C_HS_END);
    vsync_d  = (vcount_d >= C_VS_BEG) && (vcount_d < C_VS_END);
    hblnk_d  = (hcount_d >= C_H_ACTIVE);
    vblnk_d  = (vcount_d >= C_V_ACTIVE);
    fstart_d = w_frame_wrap;
    fcnt_d   = fcnt_q + {7'd0, w_frame_wrap};
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      fstart_q <= 1'b0;
      fcnt_q   <= 8'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      fstart_q <= fstart_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign hblnk_out       = hblnk_q;
  assign vblnk_out       = vblnk_q;
  assign frame_start_out = fstart_q;
  assign frame_cnt_out   = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks a reduced-size instance (full frames, counter wrap) and a
// default-size instance (real line timing) against a time-since-reset model.
`default_nettype none

module tb_vga_timing;

  // Reduced geometry keeps 256+ frames affordable.
  localparam int S_HA = 12, S_HSS = 14, S_HSW = 3, S_HT = 20;
  localparam int S_VA = 6,  S_VSS = 7,  S_VSW = 2, S_VT = 10;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int B_HA = 1024, B_HSS = 1048, B_HSW = 136, B_HT = 1344;
  localparam int B_VA = 768,  B_VSS = 771,  B_VSW = 6,   B_VT = 806;

  logic pclk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_b = 1'b1;

  logic [10:0] s_hc, s_vc, b_hc, b_vc;
  logic s_hs, s_vs, s_hb, s_vb, s_fs, b_hs, b_vs, b_hb, b_vb, b_fs;
  logic [7:0] s_fc, b_fc;

  int checks = 0;
  int errors = 0;
  longint t_s = 0, t_b = 0, cyc = 0;

  always #5 pclk = ~pclk;

  vga_timing #(
    .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_WIDTH(S_HSW), .H_TOTAL(S_HT),
    .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_WIDTH(S_VSW), .V_TOTAL(S_VT)
  ) u_small (
    .pclk(pclk), .rst(rst_s), .hcount_out(s_hc), .vcount_out(s_vc),
    .hsync_out(s_hs), .vsync_out(s_vs), .hblnk_out(s_hb), .vblnk_out(s_vb),
    .frame_start_out(s_fs), .frame_cnt_out(s_fc)
  );

  vga_timing u_big (
    .pclk(pclk), .rst(rst_b), .hcount_out(b_hc), .vcount_out(b_vc),
    .hsync_out(b_hs), .vsync_out(b_vs), .hblnk_out(b_hb), .vblnk_out(b_vb),
    .frame_start_out(b_fs), .frame_cnt_out(b_fc)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected outputs follow directly from the cycle count t since the reset state.
  task automatic check_vga(input string n, input longint t,
                           input int ha, input int hss, input int hsw, input int ht,
                           input int va, input int vss, input int vsw, input int vt,
                           input int hc, input int vc, input int hs, input int vs,
                           input int hb, input int vb, input int fs, input int fc);
    longint h, v, fr;
    h  = t % ht;
    v  = (t / ht) % vt;
    fr = t / (ht * vt);
    chk({n, ".hcount"}, hc, h);
    chk({n, ".vcount"}, vc, v);
    chk({n, ".hsync"},  hs, longint'((h >= hss) && (h < hss + hsw)));
    chk({n, ".vsync"},  vs, longint'((v >= vss) && (v < vss + vsw)));
    chk({n, ".hblnk"},  hb, longint'(h >= ha));
    chk({n, ".vblnk"},  vb, longint'(v >= va));
    chk({n, ".fstart"}, fs, longint'((t != 0) && (t % (ht * vt) == 0)));
    chk({n, ".fcnt"},   fc, fr % 256);
  endtask

  longint last_fs = -1;
  int     hs_run = 0;
  bit     hs_valid = 0;
  bit     seen255 = 0, wrapped = 0;
  int     hs_pulses = 0;

  task automatic step();
    @(posedge pclk);
    cyc++;
    t_s = rst_s ? 0 : t_s + 1;
    t_b = rst_b ? 0 : t_b + 1;
    #1;
    check_vga("small", t_s, S_HA, S_HSS, S_HSW, S_HT, S_VA, S_VSS, S_VSW, S_VT,
              s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_fs, s_fc);
    check_vga("big", t_b, B_HA, B_HSS, B_HSW, B_HT, B_VA, B_VSS, B_VSW, B_VT,
              b_hc, b_vc, b_hs, b_vs, b_hb, b_vb, b_fs, b_fc);
    if (rst_s) last_fs = -1;
    else if (s_fs) begin
      if (last_fs >= 0) chk("fstart_period", cyc - last_fs, S_FRAME);
      last_fs = cyc;
      if (s_fc == 8'd255) seen255 = 1;
      if (s_fc == 8'd0 && seen255) wrapped = 1;
    end
    if (rst_b) begin
      hs_run = 0; hs_valid = 0;
    end else if (b_hs) begin
      if (b_hc == 11'(B_HSS)) hs_valid = 1;
      hs_run++;
    end else if (hs_run != 0) begin
      if (hs_valid) begin
        chk("hsync_width", hs_run, B_HSW);
        hs_pulses++;
      end
      hs_run = 0; hs_valid = 0;
    end
  endtask

  initial begin
    int n, budget;
    // Reset held for 5 cycles.
    repeat (5) step();
    chk("reset_hcount", s_hc, 0);
    chk("reset_fcnt", b_fc, 0);
    rst_s = 1'b0;
    rst_b = 1'b0;
    step();
    chk("first_hcount", b_hc, 1);
    chk("first_vcount", b_vc, 0);

    // Three frames, then wait until frame 3 and reset at a random point.
    repeat (3 * S_FRAME) step();
    budget = 2 * S_FRAME;
    while (s_fc != 8'd3 && budget > 0) begin step(); budget--; end
    chk("reach_fcnt3", s_fc, 3);
    n = int'($urandom_range(1, S_FRAME - 2));
    repeat (n) step();
    rst_s = 1'b1;
    repeat (int'($urandom_range(1, 3))) step();
    chk("midreset_fcnt", s_fc, 0);
    chk("midreset_hcount", s_hc, 0);
    rst_s = 1'b0;

    // Long run to wrap the 8-bit frame counter.
    repeat (257 * S_FRAME + int'($urandom_range(0, S_FRAME))) step();
    chk("fcnt_wrapped", longint'(wrapped), 1);
    chk("hsync_pulses_seen", longint'(hs_pulses > 10), 1);

    // Random mid-line reset of the full-size instance.
    rst_b = 1'b1;
    repeat (int'($urandom_range(1, 4))) step();
    rst_b = 1'b0;
    repeat (B_HT + 200) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running VGA timing generator for the 1024x768@60 Hz display path (65 MHz pclk).
- Produces the pixel coordinates, sync and blanking signals that feed the first drawing stage of the pixel pipeline.
- Also produces a one-cycle frame-start strobe and an 8-bit frame counter for game-logic pacing (card flip timers, blink effects).
- Head of the pipeline; it has no video inputs.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_SYNC_START, 1048, first hcount value with hsync asserted
- H_SYNC_WIDTH, 136, hsync pulse length in pixels
- H_TOTAL, 1344, pixels per line including blanking
- V_ACTIVE, 768, visible lines per frame
- V_SYNC_START, 771, first vcount value with vsync asserted
- V_SYNC_WIDTH, 6, vsync pulse length in lines
- V_TOTAL, 806, lines per frame including blanking

Ports:
- pclk  input  1  pixel clock, 65 MHz, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- hcount_out  output  11  horizontal pixel index, 0..H_TOTAL-1
- vcount_out  output  11  vertical line index, 0..V_TOTAL-1
- hsync_out  output  1  high during horizontal sync pulse
- vsync_out  output  1  high during vertical sync pulse
- hblnk_out  output  1  high when hcount_out >= H_ACTIVE
- vblnk_out  output  1  high when vcount_out >= V_ACTIVE
- frame_start_out  output  1  one-cycle strobe at pixel (0,0) of each frame
- frame_cnt_out  output  8  frame counter, increments at each frame start

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high, clocked on pclk.
  - While rst=1, every output is 0 at the next edge: hcount_out=0, vcount_out=0, hsync_out=0, vsync_out=0, hblnk_out=0, vblnk_out=0, frame_start_out=0, frame_cnt_out=0.
- Output registration and alignment:
  - Every output is a flip-flop; no combinational path to any output.
  - All outputs are aligned: in any cycle, hsync/hblnk/vsync/vblnk/frame_start describe the same (hcount_out, vcount_out) pair.
  - Decode is therefore done on the next-count values, not the current ones.
- Horizontal counter:
  - First edge with rst=0 loads hcount_out=1; pixel (0,0) is the state held during reset.
  - Each edge: hcount_out <= hcount_out+1.
  - At H_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter:
  - vcount_out changes only on the edge where hcount wraps H_TOTAL-1 -> 0.
  - It then increments, wrapping from V_TOTAL-1 to 0.
  - Simultaneous horizontal and vertical wrap at (1343,805) -> (0,0) in one edge.
- Sync decode:
  - hsync_out=1 iff H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_WIDTH, i.e. 1048..1183.
  - vsync_out=1 iff V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_WIDTH, i.e. 771..776.
  - Both are level signals depending only on their own counter; vsync is not gated by hcount.
- Blank decode:
  - hblnk_out=1 for hcount 1024..1343.
  - vblnk_out=1 for vcount 768..805.
- Frame start and frame counter:
  - frame_start_out=1 exactly in cycles where the counts are (0,0) reached by wrap-around.
  - It is 0 in the reset state and in the first post-reset (0,0) cycle, since that cycle is the reset state.
  - frame_cnt_out increments by 1 on the same edge that asserts frame_start_out.
  - It wraps 255 -> 0 silently.
- Width rules:
  - All comparisons are unsigned 11-bit.
  - Parameter sums must stay below 2048. The defaults satisfy this; other values are out of scope.
- Reset mid-frame: asserting rst at any point forces the full reset state on the next edge. No partial frame is completed; counting restarts from (0,0) with frame_cnt_out=0.
- Timing totals:
  - Line period is 1344 cycles; frame period is 1344*806 = 1,083,264 cycles.
  - frame_start_out period equals the frame period.

Test Plan:
- Reset then release: hold rst=1 for 5 cycles -> all outputs 0. First edge after release -> hcount_out=1, vcount_out=0, all flags 0.
- Line sweep: from reset release, count edges -> hblnk_out rises when hcount_out=1024, hsync_out is high for hcount_out 1048..1183 (exactly 136 cycles), hcount_out 1343 is followed by 0, vcount_out steps 0 -> 1 on that same edge.
- Full frame: run 1,083,264 cycles -> vblnk_out high for lines 768..805, vsync_out high for lines 771..776 (6*1344 = 8064 cycles). At wrap to (0,0): frame_start_out=1 for one cycle, frame_cnt_out=1.
- Alignment check: every cycle, compare flags against a reference model decoding hcount_out/vcount_out -> zero mismatches over 3 frames. frame_start_out period is exactly 1,083,264 cycles.
- Counter wrap: run 256 frames -> frame_cnt_out reaches 255, then 0 at the 256th frame start, with no glitch on other outputs.
- Mid-frame reset: assert rst for 1 cycle at hcount=700, vcount=400 with frame_cnt_out=3 -> next edge all outputs 0. Counting resumes normally and the next frame_start_out occurs 1,083,264 cycles after release.
